// File: rtl/video_fetch.sv
// video_fetch: double line buffer that prefetches framebuffer line y+1 while line y is displayed.
module video_fetch #(
  parameter logic [22:0] SCREEN_BASE = 23'h00D380,
  parameter int          LINES       = 342,
  parameter int          WORDS       = 32
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [14:1] vid_addr,
  output logic [15:0] vid_dout,
  output logic        mem_req,
  output logic [23:1] mem_addr,
  input  logic        mem_ack,
  input  logic [15:0] mem_din,
  output logic        busy,
  output logic        overrun
);
  typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_e;
  localparam logic [9:0] LIM = 10'(LINES);
  state_e      state_q, state_d;
  logic [8:0]  y, nxt, y_last_q, target_q, target_d, pend_q, pend_d;
  logic [4:0]  word, wcnt_q, wcnt_d;
  logic        overrun_q, overrun_d, lc, nxt_ok, last;
  logic [15:0] buf0_q [WORDS];
  logic [15:0] buf1_q [WORDS];

  assign y        = vid_addr[14:6];
  assign word     = vid_addr[5:1];
  assign lc       = y != y_last_q;
  assign nxt      = y + 9'd1;
  assign nxt_ok   = {1'b0, nxt} < LIM;
  assign last     = mem_ack && wcnt_q == 5'd31;
  assign vid_dout = y[0] ? buf1_q[word] : buf0_q[word];
  assign busy     = state_q != IDLE;
  assign mem_req  = busy;
  assign mem_addr = mem_req ? SCREEN_BASE + {9'b0, target_q, 5'b0} + {18'b0, wcnt_q} : '0;
  assign overrun  = overrun_q;

  always_comb begin
    state_d   = state_q;
    target_d  = target_q;
    pend_d    = pend_q;
    wcnt_d    = wcnt_q;
    overrun_d = overrun_q;
    case (state_q)
      IDLE: if (lc && nxt_ok) begin
        state_d  = FETCH;
        target_d = nxt;
        wcnt_d   = '0;
      end
      FETCH: begin
        wcnt_d = mem_ack ? wcnt_q + 5'd1 : wcnt_q;
        if (last) begin
          // a line change on the final ack is not an overrun: chain straight into the next line
          state_d  = (lc && nxt_ok) ? FETCH : IDLE;
          target_d = lc ? nxt : target_q;
        end else if (lc) begin
          state_d   = DRAIN;
          pend_d    = nxt;
          overrun_d = 1'b1;
        end
      end
      DRAIN: begin
        pend_d    = lc ? nxt : pend_q;
        overrun_d = overrun_q | lc;
        if (mem_ack) begin
          state_d  = ({1'b0, pend_d} < LIM) ? FETCH : IDLE;
          target_d = pend_d;
          wcnt_d   = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      y_last_q  <= '0;
      target_q  <= '0;
      pend_q    <= '0;
      wcnt_q    <= '0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      y_last_q  <= y;
      target_q  <= target_d;
      pend_q    <= pend_d;
      wcnt_q    <= wcnt_d;
      overrun_q <= overrun_d;
    end
  end

  always_ff @(posedge clk) begin
    if (state_q == FETCH && mem_ack) begin
      if (target_q[0]) buf1_q[wcnt_q] <= mem_din;
      else buf0_q[wcnt_q] <= mem_din;
    end
  end
endmodule

// File: tb/tb_video_fetch.sv
// tb_video_fetch: directed scenarios for video_fetch with a memory model returning data = address.
module tb_video_fetch;
  logic        clk = 1'b0;
  logic        reset_n, mem_req, mem_ack, busy, overrun, zw, pulse;
  logic [14:1] vid_addr;
  logic [15:0] vid_dout, mem_din;
  logic [23:1] mem_addr;
  logic [22:0] ack_q [$];
  int total = 0, bad = 0;

  video_fetch dut (
    .clk(clk), .reset_n(reset_n), .vid_addr(vid_addr), .vid_dout(vid_dout),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_din(mem_din),
    .busy(busy), .overrun(overrun)
  );

  always #5 clk = ~clk;
  assign mem_ack = zw ? mem_req : pulse;
  assign mem_din = mem_addr[16:1];

  always @(negedge clk) if (mem_req && mem_ack) ack_q.push_back(mem_addr);

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (busy && n < 200);
  endtask

  task automatic ack_after(input int gap);
    repeat (gap) tick();
    pulse = 1'b1;
    tick();
    pulse = 1'b0;
  endtask

  task automatic test_reset;
    reset_n = 1'b0; vid_addr = '0; zw = 1'b0; pulse = 1'b0;
    #2;
    total++; if (mem_req !== 1'b0) begin bad++; $display("FAIL reset_req: got %b want 0", mem_req); end
    total++; if (mem_addr !== 23'h0) begin bad++; $display("FAIL reset_addr: got %h want 0", mem_addr); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
    total++; if (overrun !== 1'b0) begin bad++; $display("FAIL reset_overrun: got %b want 0", overrun); end
    tick();
    reset_n = 1'b1;
    repeat (2) tick();
    total++; if (mem_req !== 1'b0) begin bad++; $display("FAIL idle_after_reset: got %b want 0", mem_req); end
  endtask

  task automatic test_fetch;
    int n, errs;
    zw = 1'b1;
    ack_q.delete();
    vid_addr = {9'd5, 5'd0};
    wait_idle(n);
    errs = 0;
    for (int i = 0; i < 32; i++) if (ack_q[i] !== 23'(23'h00D440 + i)) errs++;
    total++; if (ack_q.size() != 32) begin bad++; $display("FAIL fetch_count: got %0d want 32", ack_q.size()); end
    total++; if (errs != 0) begin bad++; $display("FAIL fetch_addrs: got %0d wrong want 0", errs); end
    total++; if (n != 33) begin bad++; $display("FAIL fetch_cycles: got %0d want 33", n); end
    total++; if (overrun !== 1'b0) begin bad++; $display("FAIL fetch_overrun: got %b want 0", overrun); end
  endtask

  task automatic test_readback;
    int n;
    vid_addr = {9'd6, 5'd7};
    #1;
    total++; if (vid_dout !== 16'hD447) begin bad++; $display("FAIL read_w7: got %h want d447", vid_dout); end
    vid_addr = {9'd6, 5'd31};
    #1;
    total++; if (vid_dout !== 16'hD45F) begin bad++; $display("FAIL read_w31: got %h want d45f", vid_dout); end
    wait_idle(n);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL read_done: got %b want 0 after %0d", busy, n); end
  endtask

  task automatic test_boundary;
    int n;
    ack_q.delete();
    vid_addr = {9'd511, 5'd0};
    wait_idle(n);
    total++; if (ack_q.size() != 32 || ack_q[0] !== 23'h00D380) begin bad++; $display("FAIL wrap_first: got %h (%0d acks) want 00d380 (32)", ack_q[0], ack_q.size()); end
    vid_addr = {9'd0, 5'd3};
    #1;
    total++; if (vid_dout !== 16'hD383) begin bad++; $display("FAIL wrap_data: got %h want d383", vid_dout); end
    wait_idle(n);
    ack_q.delete();
    vid_addr = {9'd340, 5'd0};
    wait_idle(n);
    total++; if (ack_q.size() != 32 || ack_q[0] !== 23'h00FE20) begin bad++; $display("FAIL last_line_first: got %h want 00fe20", ack_q[0]); end
    ack_q.delete();
    vid_addr = {9'd341, 5'd4};
    repeat (5) tick();
    total++; if (mem_req !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL past_end_req: got req=%b busy=%b want 0 0", mem_req, busy); end
    total++; if (ack_q.size() != 0) begin bad++; $display("FAIL past_end_acks: got %0d want 0", ack_q.size()); end
    total++; if (vid_dout !== 16'hFE24) begin bad++; $display("FAIL past_end_data: got %h want fe24", vid_dout); end
  endtask

  task automatic test_overrun;
    int n;
    zw = 1'b0;
    ack_q.delete();
    vid_addr = {9'd10, 5'd0};
    tick();
    total++; if (mem_addr !== 23'h00D4E0) begin bad++; $display("FAIL ovr_start: got %h want 00d4e0", mem_addr); end
    repeat (10) ack_after(39);
    total++; if (mem_addr !== 23'h00D4EA || overrun !== 1'b0) begin bad++; $display("FAIL ovr_pre: got %h ovr=%b want 00d4ea 0", mem_addr, overrun); end
    vid_addr = {9'd21, 5'd0};
    tick();
    total++; if (overrun !== 1'b1 || busy !== 1'b1) begin bad++; $display("FAIL ovr_set: got ovr=%b busy=%b want 1 1", overrun, busy); end
    total++; if (mem_addr !== 23'h00D4EA) begin bad++; $display("FAIL ovr_hold: got %h want 00d4ea", mem_addr); end
    ack_after(39);
    total++; if (mem_addr !== 23'h00D640) begin bad++; $display("FAIL ovr_restart: got %h want 00d640", mem_addr); end
    total++; if (ack_q.size() != 11) begin bad++; $display("FAIL ovr_acks: got %0d want 11", ack_q.size()); end
    vid_addr = {9'd21, 5'd10};
    #1;
    total++; if (vid_dout !== 16'hFE2A) begin bad++; $display("FAIL ovr_drain_nowrite: got %h want fe2a", vid_dout); end
    vid_addr = {9'd21, 5'd9};
    #1;
    total++; if (vid_dout !== 16'hD4E9) begin bad++; $display("FAIL ovr_written: got %h want d4e9", vid_dout); end
    zw = 1'b1;
    wait_idle(n);
    total++; if (busy !== 1'b0 || overrun !== 1'b1) begin bad++; $display("FAIL ovr_sticky: got busy=%b ovr=%b want 0 1", busy, overrun); end
  endtask

  task automatic test_back_to_back;
    int n;
    reset_n = 1'b0; vid_addr = '0; zw = 1'b1;
    tick();
    reset_n = 1'b1;
    tick();
    total++; if (overrun !== 1'b0) begin bad++; $display("FAIL b2b_clear: got %b want 0", overrun); end
    vid_addr = {9'd2, 5'd0};
    repeat (32) tick();
    total++; if (mem_addr !== 23'h00D3FF) begin bad++; $display("FAIL b2b_last: got %h want 00d3ff", mem_addr); end
    vid_addr = {9'd3, 5'd31};
    tick();
    total++; if (overrun !== 1'b0 || busy !== 1'b1) begin bad++; $display("FAIL b2b_ovr: got ovr=%b busy=%b want 0 1", overrun, busy); end
    total++; if (mem_addr !== 23'h00D400) begin bad++; $display("FAIL b2b_next: got %h want 00d400", mem_addr); end
    total++; if (vid_dout !== 16'hD3FF) begin bad++; $display("FAIL b2b_word31: got %h want d3ff", vid_dout); end
    wait_idle(n);
    total++; if (busy !== 1'b0 || overrun !== 1'b0) begin bad++; $display("FAIL b2b_done: got busy=%b ovr=%b want 0 0", busy, overrun); end
  endtask

  task automatic test_async_reset;
    zw = 1'b0; pulse = 1'b0;
    vid_addr = {9'd7, 5'd0};
    repeat (2) tick();
    total++; if (mem_req !== 1'b1 || mem_addr !== 23'h00D480) begin bad++; $display("FAIL arst_pre: got req=%b addr=%h want 1 00d480", mem_req, mem_addr); end
    #2;
    reset_n = 1'b0;
    #1;
    total++; if (mem_req !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL arst_req: got req=%b busy=%b want 0 0", mem_req, busy); end
    total++; if (mem_addr !== 23'h0) begin bad++; $display("FAIL arst_addr: got %h want 0", mem_addr); end
    vid_addr = '0;
    tick();
    reset_n = 1'b1;
    repeat (2) tick();
    total++; if (mem_req !== 1'b0) begin bad++; $display("FAIL arst_after: got %b want 0", mem_req); end
  endtask

  initial begin
    test_reset();
    test_fetch();
    test_readback();
    test_boundary();
    test_overrun();
    test_back_to_back();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
